// File: rtl/spi_slave_frontend.sv
// spi_slave_frontend: SPI mode-0 pin synchroniser, edge detect and session FSM feeding a downstream shift register.
// Optional SCK glitch filter enabled by defining SPI_GLITCH_FILTER_EN.
module spi_slave_frontend #(
    parameter int N = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck_pin,
    input  logic cs_n_pin,
    input  logic mosi_pin,
    output logic miso_pin,
    output logic miso_oe,
    input  logic so,
    output logic sel,
    output logic si,
    output logic reset_flag,
    output logic word_done,
    output logic session_end,
    output logic active
);
    localparam int CW = $clog2(N);
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, LOAD, ACTIVE} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sck_s, cs_s, mosi_s, settle;
    logic sck_d, cs_d, fall_q;
    logic [CW-1:0] cnt;
    logic sck_cur, cs_cur, sck_rise, sck_fall, cs_rise, cs_fall, shift, last_bit;
    assign sck_cur = sck_s[SYNC_STAGES-1];
    assign cs_cur = cs_s[SYNC_STAGES-1];
    assign cs_rise = cs_cur & ~cs_d;
    assign cs_fall = ~cs_cur & cs_d;
    assign shift = (state == ACTIVE) && sck_rise && !cs_rise;
    assign last_bit = cnt == CW'(N - 1);
`ifdef SPI_GLITCH_FILTER_EN
    logic sck_f;
    // sck_d is the second agreement sample; sck_f is the filtered level used as edge reference
    always_ff @(posedge clk)
        sck_f <= reset ? 1'b0 : (sck_cur == sck_d ? sck_cur : sck_f);
    assign sck_rise = sck_cur & sck_d & ~sck_f;
    assign sck_fall = ~sck_cur & ~sck_d & sck_f;
`else
    assign sck_rise = sck_cur & ~sck_d;
    assign sck_fall = ~sck_cur & sck_d;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_IDLE;
            sck_s <= '0;
            cs_s <= '1;
            mosi_s <= '0;
            settle <= '0;
            sck_d <= 1'b0;
            cs_d <= 1'b1;
            fall_q <= 1'b0;
            cnt <= '0;
            sel <= 1'b0;
            si <= 1'b0;
            reset_flag <= 1'b0;
            word_done <= 1'b0;
            session_end <= 1'b0;
            active <= 1'b0;
            miso_oe <= 1'b0;
            miso_pin <= 1'b0;
        end else begin
            sck_s <= {sck_s[SYNC_STAGES-2:0], sck_pin};
            cs_s <= {cs_s[SYNC_STAGES-2:0], cs_n_pin};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi_pin};
            settle <= {settle[SYNC_STAGES-2:0], 1'b1};
            sck_d <= sck_cur;
            cs_d <= cs_cur;
            sel <= shift;
            si <= mosi_s[SYNC_STAGES-1];
            word_done <= shift && last_bit;
            reset_flag <= 1'b0;
            session_end <= 1'b0;
            fall_q <= (state == ACTIVE) && sck_fall && !cs_rise;
            if (fall_q && state == ACTIVE && !cs_rise)
                miso_pin <= so;
            if (shift)
                cnt <= last_bit ? '0 : cnt + 1'b1;
            case (state)
                // settle ensures the cs_n chain holds real pin samples, so a live frame is never joined
                WAIT_IDLE: if (settle[SYNC_STAGES-1] && cs_cur) state <= IDLE;
                IDLE: if (cs_fall) begin
                    state <= START;
                    reset_flag <= 1'b1;
                end
                START: begin
                    cnt <= '0;
                    state <= LOAD;
                end
                LOAD: begin
                    miso_pin <= so;
                    miso_oe <= 1'b1;
                    active <= 1'b1;
                    state <= ACTIVE;
                end
                ACTIVE: if (cs_rise) begin
                    session_end <= 1'b1;
                    miso_oe <= 1'b0;
                    active <= 1'b0;
                    state <= IDLE;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_frontend.sv
// tb_spi_slave_frontend: directed table-driven bench with an SPI master and a downstream shift-register model.
module tb_spi_slave_frontend;
    localparam int H = 6;
`ifdef SPI_GLITCH_FILTER_EN
    localparam int SCK_LAT = 4;
    localparam int GLITCH_SEL = 0;
`else
    localparam int SCK_LAT = 3;
    localparam int GLITCH_SEL = 1;
`endif
    logic clk = 0, reset = 1, sck_pin = 0, cs_n_pin = 1, mosi_pin = 0, so;
    logic miso_pin, miso_oe, sel, si, reset_flag, word_done, session_end, active;
    logic [7:0] sr = '0, load_val = '0;
    int n_cmp = 0, n_bad = 0;
    int sel_cnt, wd_cnt, rf_cnt, end_cnt, n_consec = 0;
    logic oe_seen;
    logic [23:0] si_acc, wd_pos, miso_acc;
    logic p_sel = 0, p_rf = 0, p_wd = 0, p_end = 0;

    spi_slave_frontend dut (
        .clk(clk), .reset(reset), .sck_pin(sck_pin), .cs_n_pin(cs_n_pin), .mosi_pin(mosi_pin),
        .miso_pin(miso_pin), .miso_oe(miso_oe), .so(so), .sel(sel), .si(si),
        .reset_flag(reset_flag), .word_done(word_done), .session_end(session_end), .active(active)
    );

    always #5 clk = ~clk;

    assign so = sr[7];
    always @(posedge clk)
        if (reset_flag) sr <= load_val;
        else if (sel) sr <= {sr[6:0], si};

    always @(negedge clk) begin
        if (sel) begin
            sel_cnt++;
            si_acc = {si_acc[22:0], si};
            if (word_done) wd_pos = wd_pos | (24'd1 << (sel_cnt - 1));
        end
        if (word_done) wd_cnt++;
        if (reset_flag) rf_cnt++;
        if (session_end) end_cnt++;
        if (miso_oe) oe_seen = 1;
        if ((sel && p_sel) || (reset_flag && p_rf) || (word_done && p_wd) || (session_end && p_end)) n_consec++;
        p_sel = sel; p_rf = reset_flag; p_wd = word_done; p_end = session_end;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        sel_cnt = 0; wd_cnt = 0; rf_cnt = 0; end_cnt = 0; oe_seen = 0;
        si_acc = '0; wd_pos = '0; miso_acc = '0;
    endtask

    task automatic xfer(input logic m);
        mosi_pin = m;
        repeat (H) @(negedge clk);
        miso_acc = {miso_acc[22:0], miso_pin};
        sck_pin = 1;
        repeat (H) @(negedge clk);
        sck_pin = 0;
    endtask

    task automatic session(input int n, input logic [23:0] m, input logic [7:0] ld);
        load_val = ld;
        cs_n_pin = 0;
        for (int i = n - 1; i >= 0; i--) xfer(m[i]);
        repeat (H) @(negedge clk);
        cs_n_pin = 1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_for(input int which, output int k);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if ((which == 0 && reset_flag) || (which == 1 && sel) || (which == 2 && session_end)) break;
        end
    endtask

    typedef struct {
        int nbits;
        logic [23:0] mosi;
        logic [7:0] load;
        int e_sel;
        int e_wd;
        logic [23:0] e_wdpos;
        logic [23:0] e_miso;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int k;
        logic [23:0] mask;
        vecs[0] = '{8,  24'hA5,     8'h3C, 8,  1, 24'h000080, 24'h3C};
        vecs[1] = '{24, 24'h123456, 8'h81, 24, 3, 24'h808080, 24'h811234};
        vecs[2] = '{5,  24'h13,     8'hF0, 5,  0, 24'h000000, 24'h1E};
        vecs[3] = '{8,  24'h5A,     8'hC3, 8,  1, 24'h000080, 24'hC3};
        repeat (3) @(negedge clk);
        check("reset_outputs", {25'd0, sel, reset_flag, word_done, session_end, active, miso_oe, miso_pin}, 0);
        reset = 0;
        repeat (8) @(negedge clk);
        check("idle_active", {31'd0, active}, 0);

        clr();
        for (int i = 0; i < 4; i++) xfer(1'b1);
        repeat (H) @(negedge clk);
        check("csh_sel", sel_cnt, 0);
        check("csh_rflag", rf_cnt, 0);
        check("csh_oe", {31'd0, oe_seen}, 0);

        for (int v = 0; v < 4; v++) begin
            clr();
            session(vecs[v].nbits, vecs[v].mosi, vecs[v].load);
            mask = (24'd1 << vecs[v].nbits) - 24'd1;
            if (vecs[v].nbits == 24) mask = '1;
            check($sformatf("v%0d_sel", v), sel_cnt, vecs[v].e_sel);
            check($sformatf("v%0d_wd", v), wd_cnt, vecs[v].e_wd);
            check($sformatf("v%0d_wdpos", v), {8'd0, wd_pos}, {8'd0, vecs[v].e_wdpos});
            check($sformatf("v%0d_si", v), {8'd0, si_acc & mask}, {8'd0, vecs[v].mosi & mask});
            check($sformatf("v%0d_miso", v), {8'd0, miso_acc & mask}, {8'd0, vecs[v].e_miso});
            check($sformatf("v%0d_rflag", v), rf_cnt, 1);
            check($sformatf("v%0d_end", v), end_cnt, 1);
            check($sformatf("v%0d_active", v), {31'd0, active}, 0);
        end

        clr();
        cs_n_pin = 0;
        wait_for(0, k);
        check("lat_rflag", k, 3);
        repeat (8) @(negedge clk);
        check("active_high", {30'd0, active, miso_oe}, 3);
        sck_pin = 1;
        wait_for(1, k);
        check("lat_sel", k, SCK_LAT);
        repeat (H) @(negedge clk);
        sck_pin = 0;
        repeat (H) @(negedge clk);
        cs_n_pin = 1;
        wait_for(2, k);
        check("lat_end", k, 3);
        repeat (10) @(negedge clk);

        clr();
        cs_n_pin = 0;
        repeat (8) @(negedge clk);
        sck_pin = 1;
        @(negedge clk);
        sck_pin = 0;
        repeat (10) @(negedge clk);
        check("glitch_sel", sel_cnt, GLITCH_SEL);
        cs_n_pin = 1;
        repeat (10) @(negedge clk);

        load_val = 8'h3C;
        cs_n_pin = 0;
        for (int i = 0; i < 3; i++) xfer(1'b1);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        clr();
        for (int i = 0; i < 4; i++) xfer(1'b0);
        check("rst_mid_sel", sel_cnt, 0);
        check("rst_mid_oe", {31'd0, oe_seen}, 0);
        check("rst_mid_rflag", rf_cnt, 0);
        cs_n_pin = 1;
        repeat (10) @(negedge clk);
        clr();
        session(8, 24'hA5, 8'h3C);
        check("post_rst_rflag", rf_cnt, 1);
        check("post_rst_sel", sel_cnt, 8);
        check("post_rst_miso", {24'd0, miso_acc[7:0]}, 32'h3C);
        check("post_rst_wd", wd_cnt, 1);

        check("no_consecutive_pulses", n_consec, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
